i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave_pkg.sv | 21 ++
 rtl/i2c_slave_if.sv | 11 +
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_slave.sv | 162 ++++++++++++++++
 tb/tb_i2c_slave.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave: FSM state encoding and bit-counter sizing.
package i2c_slave_pkg;

    localparam int BITCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    localparam logic [BITCNT_W-1:0] BIT_ONE  = BITCNT_W'(1);
    localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(7);
    localparam logic [BITCNT_W-1:0] BIT_ACK  = BITCNT_W'(8);

endpackage

// File: rtl/i2c_slave_if.sv
// Host-side view of the I2C slave: byte to send, last byte received and transfer status.
interface i2c_slave_if;
    logic [7:0] txdata;
    logic [7:0] rxdata;
    logic       ack;
    logic       r;
    logic       w;

    modport slave  (input txdata, output rxdata, output ack, output r, output w);
    modport master (output txdata, input rxdata, input ack, input r, input w);
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for scl/sda plus edge detection producing START/STOP and scl edge strobes.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic r_scl_p0, r_scl_p1, r_scl_p2;
    logic r_sda_p0, r_sda_p1, r_sda_p2;
    logic r_vld_p0, r_vld_p1, r_vld_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_p0 <= 1'b1;
            r_scl_p1 <= 1'b1;
            r_scl_p2 <= 1'b1;
            r_sda_p0 <= 1'b1;
            r_sda_p1 <= 1'b1;
            r_sda_p2 <= 1'b1;
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_scl_p0 <= i_scl;
            r_scl_p1 <= r_scl_p0;
            r_scl_p2 <= r_scl_p1;
            r_sda_p0 <= i_sda;
            r_sda_p1 <= r_sda_p0;
            r_sda_p2 <= r_sda_p1;
            r_vld_p0 <= 1'b1;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Strobes stay quiet until the preset idle values have been flushed by real
    // line samples, so a reset taken mid-transfer cannot fake a START or an edge.
    assign o_sda      = r_sda_p1;
    assign o_scl_rise = r_vld_p2 &  r_scl_p1 & ~r_scl_p2;
    assign o_scl_fall = r_vld_p2 & ~r_scl_p1 &  r_scl_p2;
    assign o_start    = r_vld_p2 &  r_scl_p1 &  r_scl_p2 & ~r_sda_p1 &  r_sda_p2;
    assign o_stop     = r_vld_p2 &  r_scl_p1 &  r_scl_p2 &  r_sda_p1 & ~r_sda_p2;
endmodule

// File: rtl/i2c_slave.sv
// I2C slave with 7-bit address: unlimited-length writes into rxdata and reads from txdata.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire         scl,
    inout  wire         sda,
    i2c_slave_if.slave  bus
);
    state_e              r_state;
    logic [BITCNT_W-1:0] r_bitcnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_rxdata;
    logic                r_sda_oe;
    logic                r_ack;
    logic                r_r;
    logic                r_w;
    logic                r_mack;

    logic       w_sda, w_rise, w_fall, w_start, w_stop;
    logic       w_sda_drv;
    logic [7:0] w_byte;

    i2c_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte = {r_shift[6:0], w_sda};

    // During a read byte the shift register MSB is the bit on the wire; elsewhere only ACK slots pull low.
    assign w_sda_drv = (r_state == ST_RD_DATA) ? ~r_shift[7] : r_sda_oe;
    assign sda       = w_sda_drv ? 1'b0 : 1'bz;
    assign scl       = 1'bz;

    assign bus.rxdata = r_rxdata;
    assign bus.ack    = r_ack;
    assign bus.r      = r_r;
    assign bus.w      = r_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_rxdata <= '0;
            r_sda_oe <= 1'b0;
            r_ack    <= 1'b0;
            r_r      <= 1'b0;
            r_w      <= 1'b0;
            r_mack   <= 1'b0;
        end else if (w_start) begin
            r_state  <= ST_ADDR;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_sda_oe <= 1'b0;
            r_ack    <= 1'b0;
            r_r      <= 1'b0;
            r_w      <= 1'b0;
        end else if (w_stop) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_sda_oe <= 1'b0;
            r_ack    <= 1'b0;
            r_r      <= 1'b0;
            r_w      <= 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_rise) begin
                    r_shift <= w_byte;
                    if (r_bitcnt == BIT_LAST) begin
                        r_bitcnt <= BIT_ACK;
                        r_state  <= (w_byte[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                    end else begin
                        r_bitcnt <= r_bitcnt + BIT_ONE;
                    end
                end
                // First fall opens the ACK slot, second fall closes it and starts the data phase.
                ST_ADDR_ACK: if (w_fall) begin
                    if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                    end else begin
                        r_sda_oe <= 1'b0;
                        r_bitcnt <= '0;
                        if (r_shift[0]) begin
                            r_r     <= 1'b1;
                            r_shift <= bus.txdata;
                            r_state <= ST_RD_DATA;
                        end else begin
                            r_w     <= 1'b1;
                            r_state <= ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: if (w_rise) begin
                    r_shift <= w_byte;
                    if (r_bitcnt == BIT_LAST) begin
                        r_bitcnt <= BIT_ACK;
                        r_rxdata <= w_byte;
                        r_state  <= ST_WR_ACK;
                    end else begin
                        r_bitcnt <= r_bitcnt + BIT_ONE;
                    end
                end
                ST_WR_ACK: if (w_fall) begin
                    if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                        r_ack    <= 1'b1;
                    end else begin
                        r_sda_oe <= 1'b0;
                        r_ack    <= 1'b0;
                        r_bitcnt <= '0;
                        r_state  <= ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (w_rise && r_bitcnt != BIT_ACK)
                        r_bitcnt <= r_bitcnt + BIT_ONE;
                    if (w_fall) begin
                        if (r_bitcnt == BIT_ACK) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_RD_ACK;
                        end else begin
                            r_shift <= {r_shift[6:0], 1'b1};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_rise)
                        r_mack <= ~w_sda;
                    if (w_fall) begin
                        r_ack <= 1'b0;
                        if (r_mack) begin
                            r_shift  <= bus.txdata;
                            r_bitcnt <= '0;
                            r_state  <= ST_RD_DATA;
                        end else begin
                            r_state  <= ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    r_sda_oe <= 1'b0;
                    r_ack    <= 1'b0;
                end
                default: begin
                    r_sda_oe <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave through directed and randomized transfers against a transaction-level model.
module tb_i2c_slave;
    logic clk = 1'b0;
    logic reset;
    logic m_scl, m_sda;
    wire  scl, sda;

    always #5 clk = ~clk;

    assign scl = m_scl ? 1'bz : 1'b0;
    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (scl);
    pullup (sda);

    i2c_slave_if bus ();

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk   (clk),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .bus   (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   ack_rises = 0;
    logic ack_q = 1'b0;

    always @(posedge clk) begin
        ack_q <= bus.ack;
        if (bus.ack && !ack_q)
            ack_rises <= ack_rises + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Quarter of an SCL period; SCL runs at clk/40.
    task automatic q();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        m_sda = 1'b0; q();
        m_scl = 1'b0; q();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; q();
        m_scl = 1'b1; q();
        m_sda = 1'b1; q();
    endtask

    task automatic clock_bit(input logic b, output logic s, output logic a, output logic [7:0] rx);
        m_sda = b; q();
        m_scl = 1'b1; q();
        s  = sda;
        a  = bus.ack;
        rx = bus.rxdata;
        q();
        m_scl = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic got_ack, output logic ack_o, output logic [7:0] rx_o);
        logic s, a;
        logic [7:0] rx;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, a, rx);
        clock_bit(1'b1, s, ack_o, rx_o);
        got_ack = ~s;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d, output logic ack_o);
        logic s, a;
        logic [7:0] rx;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s, a, rx);
            d[i] = s;
        end
        bus.txdata = next_tx;
        clock_bit(~mack, s, ack_o, rx);
    endtask

    logic       ga, ao, hit, rw;
    logic [7:0] rxo, rd, wb, exp_rx;
    logic [6:0] a7;
    logic [7:0] txq[$];
    int         n, base;

    initial begin
        m_scl = 1'b1;
        m_sda = 1'b1;
        bus.txdata = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rxdata", bus.rxdata, 8'h00);
        check("rst_ack", bus.ack, 1'b0);
        check("rst_r", bus.r, 1'b0);
        check("rst_w", bus.w, 1'b0);
        check("rst_sda", sda, 1'b1);
        reset = 1'b0;
        q();

        // Write 0x02, 0x5A
        base = ack_rises;
        start_cond();
        write_byte(8'hA0, ga, ao, rxo);
        check("w1_addr_ack", ga, 1'b1);
        check("w1_addr_ackflag", ao, 1'b0);
        write_byte(8'h02, ga, ao, rxo);
        check("w1_b0_ack", ga, 1'b1);
        check("w1_b0_ackflag", ao, 1'b1);
        check("w1_b0_rx", rxo, 8'h02);
        check("w1_w_active", bus.w, 1'b1);
        write_byte(8'h5A, ga, ao, rxo);
        check("w1_b1_ack", ga, 1'b1);
        check("w1_b1_ackflag", ao, 1'b1);
        check("w1_b1_rx", rxo, 8'h5A);
        stop_cond();
        check("w1_w_after_stop", bus.w, 1'b0);
        check("w1_ack_pulses", ack_rises - base, 2);

        // Write pointer, repeated START, read one byte
        start_cond();
        write_byte(8'hA0, ga, ao, rxo);
        write_byte(8'h00, ga, ao, rxo);
        check("rs_wr_ack", ga, 1'b1);
        check("rs_wr_rx", rxo, 8'h00);
        bus.txdata = 8'h05;
        start_cond();
        check("rs_w_cleared", bus.w, 1'b0);
        write_byte(8'hA1, ga, ao, rxo);
        check("rs_rd_addr_ack", ga, 1'b1);
        check("rs_r_active", bus.r, 1'b1);
        read_byte(1'b0, 8'h77, rd, ao);
        check("rs_rd_data", rd, 8'h05);
        check("rs_rd_ackflag", ao, 1'b1);
        stop_cond();
        check("rs_r_after_stop", bus.r, 1'b0);

        // Wrong address is ignored until STOP
        base = ack_rises;
        start_cond();
        write_byte(8'hA4, ga, ao, rxo);
        check("na_addr_nack", ga, 1'b0);
        write_byte(8'h11, ga, ao, rxo);
        check("na_data_nack", ga, 1'b0);
        check("na_r", bus.r, 1'b0);
        check("na_w", bus.w, 1'b0);
        check("na_rx_kept", bus.rxdata, 8'h00);
        stop_cond();
        check("na_ack_pulses", ack_rises - base, 0);

        // Two-byte read with txdata changing between bytes
        base = ack_rises;
        bus.txdata = 8'h05;
        start_cond();
        write_byte(8'hA1, ga, ao, rxo);
        read_byte(1'b1, 8'h06, rd, ao);
        check("rd2_b0", rd, 8'h05);
        read_byte(1'b0, 8'h00, rd, ao);
        check("rd2_b1", rd, 8'h06);
        stop_cond();
        check("rd2_ack_pulses", ack_rises - base, 2);

        // Reset while the slave pulls sda low in the address ACK slot
        start_cond();
        for (int i = 7; i >= 0; i--) begin
            logic s, a;
            logic [7:0] rx;
            wb = 8'hA0;
            clock_bit(wb[i], s, a, rx);
        end
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        check("rst_ack_slot_driven", sda, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sda_released", sda, 1'b1);
        reset = 1'b0;
        q();
        m_scl = 1'b0; q();
        stop_cond();

        // Reset during data bit 4 of a write, then a clean write
        start_cond();
        write_byte(8'hA0, ga, ao, rxo);
        for (int i = 0; i < 4; i++) begin
            logic s, a;
            logic [7:0] rx;
            clock_bit(1'b0, s, a, rx);
        end
        m_sda = 1'b0; q();
        m_scl = 1'b1; q();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rmid_w", bus.w, 1'b0);
        check("rmid_ack", bus.ack, 1'b0);
        check("rmid_r", bus.r, 1'b0);
        check("rmid_rx", bus.rxdata, 8'h00);
        q();
        m_scl = 1'b0; q();
        for (int i = 0; i < 3; i++) begin
            logic s, a;
            logic [7:0] rx;
            clock_bit(1'b0, s, a, rx);
        end
        clock_bit(1'b1, ga, ao, rxo);
        check("rmid_ignored_slot", ga, 1'b1);
        stop_cond();
        start_cond();
        write_byte(8'hA0, ga, ao, rxo);
        check("rpost_addr_ack", ga, 1'b1);
        write_byte(8'h3C, ga, ao, rxo);
        check("rpost_data_ack", ga, 1'b1);
        check("rpost_rx", rxo, 8'h3C);
        stop_cond();
        exp_rx = 8'h3C;

        // Randomized transactions against a transaction-level model
        for (int t = 0; t < 16; t++) begin
            a7  = ($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom_range(0, 127));
            hit = (a7 == 7'h50);
            rw  = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 4);
            txq.delete();
            for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
            base = ack_rises;
            bus.txdata = txq[0];
            start_cond();
            write_byte({a7, rw}, ga, ao, rxo);
            check("rnd_addr_ack", ga, hit);
            check("rnd_addr_ackflag", ao, 1'b0);
            for (int k = 0; k < n; k++) begin
                if (rw) begin
                    read_byte(k < n - 1, (k + 1 < n) ? txq[k + 1] : 8'($urandom), rd, ao);
                    check("rnd_rd_data", rd, hit ? txq[k] : 8'hFF);
                    check("rnd_rd_ackflag", ao, hit);
                    check("rnd_r", bus.r, hit);
                end else begin
                    wb = txq[k];
                    write_byte(wb, ga, ao, rxo);
                    if (hit) exp_rx = wb;
                    check("rnd_wr_ack", ga, hit);
                    check("rnd_wr_ackflag", ao, hit);
                    check("rnd_wr_rx", rxo, exp_rx);
                    check("rnd_w", bus.w, hit);
                end
            end
            stop_cond();
            check("rnd_r_stop", bus.r, 1'b0);
            check("rnd_w_stop", bus.w, 1'b0);
            check("rnd_rx_hold", bus.rxdata, exp_rx);
            check("rnd_ack_pulses", ack_rises - base, hit ? n : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
